// File: rtl/debug_bridge_pkg.sv
// Shared definitions for the JTAG-to-system-clock debug command bridge:
// FSM state encoding and default geometry of the instruction/scan registers.
package debug_bridge_pkg;

  localparam int DEF_IR_W    = 2;
  localparam int DEF_SR_W    = 38;
  localparam int DEF_ACT_BIT = 34;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_ISSUE   = 2'd2,
    ST_WAIT    = 2'd3
  } bridge_state_e;

endpackage

// File: rtl/debug_sysclk_cmd_bridge_if.sv
// Signal bundle between the JTAG-side update levels / consumer and the bridge.
// The bridge connects through the slave modport; its environment uses master.
interface debug_sysclk_cmd_bridge_if
  import debug_bridge_pkg::*;
#(
  parameter int IR_W = DEF_IR_W,
  parameter int SR_W = DEF_SR_W
) ();

  localparam int NUM_CMD = 2 ** IR_W;

  logic               vs_udr;
  logic               vs_uir;
  logic [IR_W-1:0]    ir_in;
  logic [SR_W-1:0]    sr;
  logic               cmd_ready;
  logic               overrun_clr;
  logic [SR_W-1:0]    jdo;
  logic [NUM_CMD-1:0] take_action;
  logic [NUM_CMD-1:0] take_no_action;
  logic               cmd_valid;
  logic [IR_W-1:0]    cmd_code;
  logic               ir_update;
  logic               overrun;

  modport slave (
    input  vs_udr, vs_uir, ir_in, sr, cmd_ready, overrun_clr,
    output jdo, take_action, take_no_action, cmd_valid, cmd_code, ir_update, overrun
  );

  modport master (
    output vs_udr, vs_uir, ir_in, sr, cmd_ready, overrun_clr,
    input  jdo, take_action, take_no_action, cmd_valid, cmd_code, ir_update, overrun
  );

endinterface

// File: rtl/debug_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level followed by a rising-edge
// pulse. The detector arms only after a genuine low sample, so a level already
// high when reset releases never produces a pulse.
module debug_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   hist_q;
  logic                   armed_q;

  // NOTE: state flops use non-blocking assignments so every stage samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      fill_q  <= '0;
      hist_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      hist_q <= sync_q[SYNC_STAGES-1];
      // fill_q marks that the last stage holds a real sample, not a reset zero
      if (fill_q[SYNC_STAGES-1] && !sync_q[SYNC_STAGES-1]) armed_q <= 1'b1;
    end
  end

  assign rise = armed_q & sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/debug_sysclk_cmd_bridge.sv
// Moves JTAG update-DR commands into the system clock domain as one-hot
// action strobes plus a valid/ready handshake. Define DBG_OVERRUN_CNT_EN to add ovr_cnt.
module debug_sysclk_cmd_bridge
  import debug_bridge_pkg::*;
#(
  parameter int IR_W        = DEF_IR_W,
  parameter int SR_W        = DEF_SR_W,
  parameter int ACT_BIT     = DEF_ACT_BIT,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  debug_sysclk_cmd_bridge_if.slave bus
`ifdef DBG_OVERRUN_CNT_EN
  ,
  output logic [7:0] ovr_cnt
`endif
);

  localparam int NUM_CMD = 2 ** IR_W;

  bridge_state_e      state_q, state_d;
  logic               udr_rise, uir_rise;
  logic               accept, drop;
  logic [SR_W-1:0]    jdo_q;
  logic [IR_W-1:0]    cmd_code_q;
  logic               overrun_q;
  logic [NUM_CMD-1:0] code_onehot;

  debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_udr_edge (
    .clk(clk), .reset(reset), .async_in(bus.vs_udr), .rise(udr_rise)
  );

  debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_uir_edge (
    .clk(clk), .reset(reset), .async_in(bus.vs_uir), .rise(uir_rise)
  );

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (udr_rise) begin
          state_d = ST_CAPTURE;
          accept  = 1'b1;
        end
      end
      ST_CAPTURE: begin
        state_d = ST_ISSUE;
        drop    = udr_rise;
      end
      ST_ISSUE, ST_WAIT: begin
        // an edge arriving with the completing handshake starts the next command
        if (bus.cmd_ready) begin
          state_d = udr_rise ? ST_CAPTURE : ST_IDLE;
          accept  = udr_rise;
        end else begin
          state_d = ST_WAIT;
          drop    = udr_rise;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      jdo_q      <= '0;
      cmd_code_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        jdo_q      <= bus.sr;
        cmd_code_q <= bus.ir_in;
      end
      if (drop)                 overrun_q <= 1'b1;
      else if (bus.overrun_clr) overrun_q <= 1'b0;
    end
  end

`ifdef DBG_OVERRUN_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovr_cnt <= 8'd0;
    end else if (drop) begin
      if (bus.overrun_clr)        ovr_cnt <= 8'd1;
      else if (ovr_cnt != 8'hFF)  ovr_cnt <= ovr_cnt + 8'd1;
    end else if (bus.overrun_clr) begin
      ovr_cnt <= 8'd0;
    end
  end
`endif

  assign code_onehot = NUM_CMD'(1) << cmd_code_q;

  assign bus.jdo            = jdo_q;
  assign bus.cmd_code       = cmd_code_q;
  assign bus.cmd_valid      = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign bus.take_action    = (state_q == ST_ISSUE &&  jdo_q[ACT_BIT]) ? code_onehot : '0;
  assign bus.take_no_action = (state_q == ST_ISSUE && !jdo_q[ACT_BIT]) ? code_onehot : '0;
  assign bus.ir_update      = uir_rise;
  assign bus.overrun        = overrun_q;

endmodule

// File: tb/tb_debug_sysclk_cmd_bridge.sv
// Directed self-checking bench for debug_sysclk_cmd_bridge (default parameters).
// Define DBG_OVERRUN_CNT_EN for both bench and RTL to exercise ovr_cnt.
module tb_debug_sysclk_cmd_bridge;

  localparam int IR_W    = 2;
  localparam int SR_W    = 38;
  localparam int NUM_CMD = 4;

  localparam logic [SR_W-1:0] SR_A = 38'h05_A5A5_A5A5; // bit 34 set
  localparam logic [SR_W-1:0] SR_B = 38'h01_2345_6789; // bit 34 clear
  localparam logic [SR_W-1:0] SR_C = 38'h3B_FFFF_0000; // bit 34 clear

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  debug_sysclk_cmd_bridge_if #(.IR_W(IR_W), .SR_W(SR_W)) bus ();

`ifdef DBG_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt;
`endif

  debug_sysclk_cmd_bridge #(
    .IR_W(IR_W), .SR_W(SR_W), .ACT_BIT(34), .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef DBG_OVERRUN_CNT_EN
    ,
    .ovr_cnt(ovr_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [2*NUM_CMD+2:0] got;
    reset           = 1'b1;
    bus.vs_udr      = 1'b0;
    bus.vs_uir      = 1'b0;
    bus.ir_in       = '0;
    bus.sr          = '0;
    bus.cmd_ready   = 1'b1;
    bus.overrun_clr = 1'b0;
    repeat (3) tick();
    got = {bus.take_action, bus.take_no_action, bus.cmd_valid, bus.overrun, bus.ir_update};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0", got);
    end
    checks++;
    if ({bus.jdo, bus.cmd_code} !== '0) begin
      errors++;
      $display("FAIL reset_data: got jdo=%h code=%b expected 0", bus.jdo, bus.cmd_code);
    end
    reset = 1'b0;
    repeat (5) tick();
    got = {bus.take_action, bus.take_no_action, bus.cmd_valid, bus.overrun, bus.ir_update};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL post_reset_idle: got %b expected 0", got);
    end
  endtask

  // Single command with cmd_ready already high: strobe at edge+4, valid one cycle.
  task automatic test_cmd(input string name, input logic [SR_W-1:0] sr_v,
                          input logic [IR_W-1:0] ir_v,
                          input logic [NUM_CMD-1:0] exp_act,
                          input logic [NUM_CMD-1:0] exp_noact);
    logic [2*NUM_CMD:0] got, exp;
    bus.sr        = sr_v;
    bus.ir_in     = ir_v;
    bus.cmd_ready = 1'b1;
    bus.vs_udr    = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      got = {bus.take_action, bus.take_no_action, bus.cmd_valid};
      exp = (i == 4) ? {exp_act, exp_noact, 1'b1} : '0;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s_strobe cyc %0d: got %b expected %b", name, i, got, exp);
      end
      checks++;
      if ($countones(bus.take_action | bus.take_no_action) > 1) begin
        errors++;
        $display("FAIL %s_onehot cyc %0d: got act=%b noact=%b expected at most one bit",
                 name, i, bus.take_action, bus.take_no_action);
      end
      if (i == 4) begin
        checks++;
        if (bus.jdo !== sr_v || bus.cmd_code !== ir_v) begin
          errors++;
          $display("FAIL %s_data: got jdo=%h code=%b expected jdo=%h code=%b",
                   name, bus.jdo, bus.cmd_code, sr_v, ir_v);
        end
      end
      if (i == 6) bus.vs_udr = 1'b0;
    end
  endtask

  // vs_uir and vs_udr rise together: ir_update at edge+2, strobe at edge+4.
  task automatic test_ir_update();
    logic [NUM_CMD+1:0] got, exp;
    bus.sr        = SR_A;
    bus.ir_in     = 2'b10;
    bus.cmd_ready = 1'b1;
    bus.vs_udr    = 1'b1;
    bus.vs_uir    = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      got = {bus.take_action, bus.cmd_valid, bus.ir_update};
      exp = {(i == 4) ? 4'b0100 : 4'b0000, i == 4, i == 2};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL ir_update cyc %0d: got %b expected %b", i, got, exp);
      end
      if (i == 6) begin
        bus.vs_udr = 1'b0;
        bus.vs_uir = 1'b0;
      end
    end
  endtask

  // Consumer stalls; second command lands in WAIT and is dropped. The drop
  // coincides with overrun_clr, which must lose.
  task automatic test_overrun();
    logic [2*NUM_CMD:0] got, exp;
    bus.cmd_ready = 1'b0;
    bus.sr        = SR_A;
    bus.ir_in     = 2'b10;
    bus.vs_udr    = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      got = {bus.take_action, bus.take_no_action, bus.cmd_valid};
      exp = {(i == 4) ? 4'b0100 : 4'b0000, 4'b0000, (i >= 4 && i <= 16)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL overrun_strobe cyc %0d: got %b expected %b", i, got, exp);
      end
      if (i == 12 || i == 13 || i == 19) begin
        checks++;
        if (bus.overrun !== (i == 13)) begin
          errors++;
          $display("FAIL overrun_flag cyc %0d: got %b expected %b", i, bus.overrun, i == 13);
        end
      end
`ifdef DBG_OVERRUN_CNT_EN
      if (i == 13 || i == 19) begin
        checks++;
        if (ovr_cnt !== ((i == 13) ? 8'd1 : 8'd0)) begin
          errors++;
          $display("FAIL overrun_cnt cyc %0d: got %0d expected %0d", i, ovr_cnt, (i == 13) ? 1 : 0);
        end
      end
`endif
      if (i == 14) begin
        checks++;
        if (bus.jdo !== SR_A || bus.cmd_code !== 2'b10) begin
          errors++;
          $display("FAIL overrun_hold: got jdo=%h code=%b expected jdo=%h code=10",
                   bus.jdo, bus.cmd_code, SR_A);
        end
      end
      case (i)
        6:  bus.vs_udr = 1'b0;
        10: begin bus.vs_udr = 1'b1; bus.sr = SR_B; bus.ir_in = 2'b01; end
        12: bus.overrun_clr = 1'b1;
        13: bus.overrun_clr = 1'b0;
        16: begin bus.cmd_ready = 1'b1; bus.vs_udr = 1'b0; end
        18: bus.overrun_clr = 1'b1;
        19: bus.overrun_clr = 1'b0;
        default: ;
      endcase
    end
  endtask

  // Second edge arrives in the very cycle the WAIT handshake completes.
  task automatic test_back_to_back();
    logic [2*NUM_CMD:0] got, exp;
    bus.cmd_ready = 1'b0;
    bus.sr        = SR_A;
    bus.ir_in     = 2'b00;
    bus.vs_udr    = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      tick();
      got = {bus.take_action, bus.take_no_action, bus.cmd_valid};
      exp = {(i == 4) ? 4'b0001 : 4'b0000, (i == 14) ? 4'b1000 : 4'b0000,
             ((i >= 4 && i <= 12) || i == 14)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL b2b_strobe cyc %0d: got %b expected %b", i, got, exp);
      end
      if (i == 13 || i == 16) begin
        checks++;
        if (bus.overrun !== 1'b0) begin
          errors++;
          $display("FAIL b2b_overrun cyc %0d: got %b expected 0", i, bus.overrun);
        end
      end
      if (i == 14) begin
        checks++;
        if (bus.jdo !== SR_C || bus.cmd_code !== 2'b11) begin
          errors++;
          $display("FAIL b2b_data: got jdo=%h code=%b expected jdo=%h code=11",
                   bus.jdo, bus.cmd_code, SR_C);
        end
      end
      case (i)
        6:  bus.vs_udr = 1'b0;
        10: begin bus.vs_udr = 1'b1; bus.sr = SR_C; bus.ir_in = 2'b11; end
        12: bus.cmd_ready = 1'b1;
        16: bus.vs_udr = 1'b0;
        default: ;
      endcase
    end
  endtask

  // Reset lands in WAIT with vs_udr still high: everything clears, and no
  // strobe appears until vs_udr falls and rises again.
  task automatic test_reset_mid();
    logic [2*NUM_CMD:0] got, exp;
    bus.cmd_ready = 1'b0;
    bus.sr        = SR_A;
    bus.ir_in     = 2'b01;
    bus.vs_udr    = 1'b1;
    repeat (4) tick();
    checks++;
    if (bus.take_action !== 4'b0010) begin
      errors++;
      $display("FAIL mid_pre_strobe: got %b expected 0010", bus.take_action);
    end
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.take_action, bus.take_no_action, bus.cmd_valid, bus.overrun, bus.ir_update,
         bus.jdo, bus.cmd_code} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got valid=%b jdo=%h code=%b expected all 0",
               bus.cmd_valid, bus.jdo, bus.cmd_code);
    end
    repeat (2) tick();
    reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      got = {bus.take_action, bus.take_no_action, bus.cmd_valid};
      checks++;
      if (got !== '0) begin
        errors++;
        $display("FAIL mid_no_strobe cyc %0d: got %b expected 0", i, got);
      end
    end
    bus.vs_udr = 1'b0;
    repeat (4) tick();
    bus.cmd_ready = 1'b1;
    bus.sr        = SR_C;
    bus.ir_in     = 2'b10;
    bus.vs_udr    = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      got = {bus.take_action, bus.take_no_action, bus.cmd_valid};
      exp = (i == 4) ? {4'b0000, 4'b0100, 1'b1} : '0;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL mid_new_cmd cyc %0d: got %b expected %b", i, got, exp);
      end
      if (i == 6) bus.vs_udr = 1'b0;
    end
  endtask

`ifdef DBG_OVERRUN_CNT_EN
  task automatic test_ovr_cnt();
    bus.cmd_ready = 1'b0;
    bus.sr        = SR_A;
    bus.ir_in     = 2'b00;
    bus.vs_udr    = 1'b1;
    repeat (6) tick();
    bus.vs_udr = 1'b0;
    repeat (3) tick();
    for (int n = 0; n < 300; n++) begin
      bus.vs_udr = 1'b1;
      repeat (2) tick();
      bus.vs_udr = 1'b0;
      repeat (2) tick();
    end
    repeat (4) tick();
    checks++;
    if (ovr_cnt !== 8'd255 || bus.overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_cnt_sat: got cnt=%0d ovr=%b expected cnt=255 ovr=1", ovr_cnt, bus.overrun);
    end
    bus.overrun_clr = 1'b1;
    tick();
    bus.overrun_clr = 1'b0;
    checks++;
    if (ovr_cnt !== 8'd0 || bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_cnt_clr: got cnt=%0d ovr=%b expected cnt=0 ovr=0", ovr_cnt, bus.overrun);
    end
    bus.cmd_ready = 1'b1;
    repeat (2) tick();
    checks++;
    if (bus.cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovr_cnt_drain: got valid=%b expected 0", bus.cmd_valid);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_cmd("action", SR_A, 2'b01, 4'b0010, 4'b0000);
    test_cmd("no_action", SR_C, 2'b11, 4'b0000, 4'b1000);
    test_ir_update();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
`ifdef DBG_OVERRUN_CNT_EN
    test_ovr_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

endmodule
